// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one downstream memory port among PORT_COUNT cache-side requesters
// Ports: clk, rst (sync active-high); per-port flattened addr/din/re/we in, dout/ready out;
//        downstream maddr/mout/mre/mwe out, min/mready in.
// Define MEM_ARBITER_FIXED_PRIORITY_EN for lowest-index-wins grants instead of round-robin.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 64,
   parameter int WORD_WIDTH = 64,
   parameter int PORT_COUNT = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [PORT_COUNT*ADDR_WIDTH-1:0] addr,
   input  logic [PORT_COUNT*WORD_WIDTH-1:0] din,
   output logic [PORT_COUNT*WORD_WIDTH-1:0] dout,
   input  logic [PORT_COUNT-1:0]            re,
   input  logic [PORT_COUNT-1:0]            we,
   output logic [PORT_COUNT-1:0]            ready,
   output logic [ADDR_WIDTH-1:0]            maddr,
   output logic [WORD_WIDTH-1:0]            mout,
   input  logic [WORD_WIDTH-1:0]            min,
   output logic                             mre,
   output logic                             mwe,
   input  logic                             mready
);
   localparam int PORT_BITS = $clog2(PORT_COUNT);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   state_t state_q, state_d;
   logic [PORT_COUNT-1:0] pending_q, pending_d, rd_q, rd_d;
   logic [PORT_COUNT-1:0][ADDR_WIDTH-1:0] a_q, a_d;
   logic [PORT_COUNT-1:0][WORD_WIDTH-1:0] w_q, w_d, dout_q, dout_d;
   logic [PORT_BITS-1:0] gnt_q, gnt_d, sel, idx;
   logic mre_q, mre_d, mwe_q, mwe_d;
`ifndef MEM_ARBITER_FIXED_PRIORITY_EN
   logic [PORT_BITS-1:0] last_q, last_d;
`endif
   assign ready = ~pending_q;
   assign dout  = dout_q;
   assign mre   = mre_q;
   assign mwe   = mwe_q;
   assign maddr = state_q == IDLE ? '0 : a_q[gnt_q];
   assign mout  = state_q == IDLE ? '0 : w_q[gnt_q];
   always_comb begin
      sel = '0;
      idx = '0;
`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
      for (int i = PORT_COUNT - 1; i >= 0; i--) begin
         idx = PORT_BITS'(i);
         if (pending_q[idx]) sel = idx;
      end
`else
      for (int i = PORT_COUNT; i >= 1; i--) begin
         idx = PORT_BITS'((int'(last_q) + i) % PORT_COUNT);
         if (pending_q[idx]) sel = idx;
      end
`endif
   end
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      rd_d      = rd_q;
      a_d       = a_q;
      w_d       = w_q;
      dout_d    = dout_q;
      gnt_d     = gnt_q;
      mre_d     = 1'b0;
      mwe_d     = 1'b0;
`ifndef MEM_ARBITER_FIXED_PRIORITY_EN
      last_d    = last_q;
`endif
      for (int i = 0; i < PORT_COUNT; i++)
         if (!pending_q[i] && (re[i] || we[i])) begin
            pending_d[i] = 1'b1;
            rd_d[i]      = re[i];
            a_d[i]       = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_d[i]       = din[i*WORD_WIDTH +: WORD_WIDTH];
         end
      case (state_q)
         IDLE:
            if (|pending_q && mready) begin
               gnt_d   = sel;
               mre_d   = rd_q[sel];
               mwe_d   = !rd_q[sel];
               state_d = ISSUE;
            end
         ISSUE: state_d = WAIT;
         WAIT:
            if (mready) begin
               if (rd_q[gnt_q]) dout_d[gnt_q] = min;
               pending_d[gnt_q] = 1'b0;
`ifndef MEM_ARBITER_FIXED_PRIORITY_EN
               last_d = gnt_q;
`endif
               state_d = IDLE;
            end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= '0;
         rd_q      <= '0;
         a_q       <= '0;
         w_q       <= '0;
         dout_q    <= '0;
         gnt_q     <= '0;
         mre_q     <= 1'b0;
         mwe_q     <= 1'b0;
`ifndef MEM_ARBITER_FIXED_PRIORITY_EN
         last_q    <= PORT_BITS'(PORT_COUNT - 1);
`endif
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         rd_q      <= rd_d;
         a_q       <= a_d;
         w_q       <= w_d;
         dout_q    <= dout_d;
         gnt_q     <= gnt_d;
         mre_q     <= mre_d;
         mwe_q     <= mwe_d;
`ifndef MEM_ARBITER_FIXED_PRIORITY_EN
         last_q    <= last_d;
`endif
      end
endmodule
